// File: rtl/tx_intf_pkg.sv
// Shared definitions for the tx status FIFO bank: register addresses,
// the empty marker, word-field positions and the unpacked record type.
package tx_intf_pkg;

    // Core addresses of the four status words, popped in this order
    localparam logic [4:0]  TXST_ADDR_W1 = 5'h16;
    localparam logic [4:0]  TXST_ADDR_W2 = 5'h17;
    localparam logic [4:0]  TXST_ADDR_W3 = 5'h18;
    localparam logic [4:0]  TXST_ADDR_W4 = 5'h19;

    // Word 1 reads as all ones when the bank is empty; bit 4 of a real
    // word 1 is always 0, so the marker cannot collide with data.
    localparam logic [31:0] TXST_EMPTY   = 32'hFFFF_FFFF;

    // Word 1 field LSB positions
    localparam int W1_CW_LSB   = 28;
    localparam int W1_SLOT_LSB = 19;
    localparam int W1_PRIO_LSB = 17;
    localparam int W1_QIDX_LSB = 15;
    localparam int W1_BD_LSB   = 5;
    localparam int W1_RETX_LSB = 0;

    // Word 2 field LSB positions
    localparam int W2_SSN_LSB  = 6;
    localparam int W2_PKT_LSB  = 0;

    typedef struct packed {
        logic [3:0]  cw;
        logic [8:0]  num_slot;
        logic [1:0]  linux_prio;
        logic [1:0]  queue_idx;
        logic [5:0]  bd_idx;
        logic [3:0]  num_retrans;
        logic [11:0] ssn;
        logic [5:0]  pkt_cnt;
        logic [63:0] bitmap;
    } tx_status_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POLL = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_RD3  = 3'd4,
        ST_RD4  = 3'd5,
        ST_OUT  = 3'd6,
        ST_GAP  = 3'd7
    } drain_state_t;

    // True for any of the four status-word addresses
    function automatic logic is_txst_addr(input logic [4:0] addr);
        return (addr >= TXST_ADDR_W1) && (addr <= TXST_ADDR_W4);
    endfunction

endpackage

// File: rtl/tx_status_unpack.sv
// Combinational extraction of the typed status record from the four raw
// status words. Reserved bits are dropped without any consistency check.
module tx_status_unpack
    import tx_intf_pkg::*;
(
    input  logic [31:0]    w1,
    input  logic [31:0]    w2,
    input  logic [31:0]    w3,
    input  logic [31:0]    w4,
    output tx_status_rec_t rec
);

    // Reserved bits are intentionally unused
    logic unused_reserved;
    assign unused_reserved = ^{w1[14:11], w1[4], w2[31:18]};

    // Slice each field out of its word
    always_comb begin
        rec             = '0;
        rec.cw          = w1[W1_CW_LSB   +: 4];
        rec.num_slot    = w1[W1_SLOT_LSB +: 9];
        rec.linux_prio  = w1[W1_PRIO_LSB +: 2];
        rec.queue_idx   = w1[W1_QIDX_LSB +: 2];
        rec.bd_idx      = w1[W1_BD_LSB   +: 6];
        rec.num_retrans = w1[W1_RETX_LSB +: 4];
        rec.ssn         = w2[W2_SSN_LSB  +: 12];
        rec.pkt_cnt     = w2[W2_PKT_LSB  +: 6];
        rec.bitmap      = {w4, w3};
    end

endmodule

// File: rtl/tx_status_drain.sv
// Hardware drain of the tx status FIFO bank. When enabled it polls word 1,
// pops the four status words through the shared rden/araddr strobes and
// offers the unpacked record on a valid/ready stream. When disabled the
// software strobes pass straight through.
//
// Record stream: rec_valid is asserted while a record is held. rec_valid
// and every rec_* field stay constant until a cycle with rec_valid = 1 and
// rec_ready = 1; that cycle is the transfer. rec_valid never depends
// combinationally on rec_ready.
module tx_status_drain
    import tx_intf_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int IRQ_THRESH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             sw_rden,
    input  logic [4:0]       sw_araddr,
    output logic             fifo_rden,
    output logic [4:0]       fifo_araddr,
    input  logic [31:0]      st_w1,
    input  logic [31:0]      st_w2,
    input  logic [31:0]      st_w3,
    input  logic [31:0]      st_w4,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [3:0]       rec_cw,
    output logic [8:0]       rec_num_slot,
    output logic [1:0]       rec_linux_prio,
    output logic [1:0]       rec_queue_idx,
    output logic [5:0]       rec_bd_idx,
    output logic [3:0]       rec_num_retrans,
    output logic [11:0]      rec_ssn,
    output logic [5:0]       rec_pkt_cnt,
    output logic [63:0]      rec_bitmap,
    output logic             irq,
    output logic [CNT_W-1:0] rec_cnt,
    output logic [CNT_W-1:0] sw_drop_cnt,
    output logic [2:0]       dbg_state
);

    localparam int              GAP_W    = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam int              PEND_W   = $clog2(IRQ_THRESH + 2);

    drain_state_t     state_q, state_d;
    logic [GAP_W-1:0] gap_q;
    logic [31:0]      w1_q, w2_q, w3_q, w4_q;
    logic [PEND_W-1:0] pend_q;
    logic [8:0]       stall_q;
    logic [CNT_W-1:0] rec_cnt_q, drop_cnt_q;
    logic             fsm_rden;
    logic [4:0]       fsm_addr;
    logic             sw_hit;
    logic             handshake;
    tx_status_rec_t   rec;

    assign handshake = (state_q == ST_OUT) && rec_ready;
    assign sw_hit    = enable && sw_rden && is_txst_addr(sw_araddr);

    // Next-state and FSM-owned strobes
    always_comb begin
        state_d  = state_q;
        fsm_rden = 1'b0;
        fsm_addr = TXST_ADDR_W1;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_POLL;
            ST_POLL: begin
                if (!enable)                 state_d = ST_IDLE;
                else if (st_w1 != TXST_EMPTY) state_d = ST_RD1;
            end
            ST_RD1: begin
                fsm_rden = 1'b1;
                fsm_addr = TXST_ADDR_W1;
                state_d  = ST_RD2;
            end
            ST_RD2: begin
                fsm_rden = 1'b1;
                fsm_addr = TXST_ADDR_W2;
                state_d  = ST_RD3;
            end
            ST_RD3: begin
                fsm_rden = 1'b1;
                fsm_addr = TXST_ADDR_W3;
                state_d  = ST_RD4;
            end
            ST_RD4: begin
                fsm_rden = 1'b1;
                fsm_addr = TXST_ADDR_W4;
                state_d  = ST_OUT;
            end
            ST_OUT: if (rec_ready) state_d = ST_GAP;
            ST_GAP: begin
                if (!enable)               state_d = ST_IDLE;
                else if (gap_q == GAP_LAST) state_d = ST_POLL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobe mux: an in-flight FSM pop wins (even if enable has just
    // dropped, the record is finished); otherwise software passes through
    // unless it targets a status word while the block owns them. Nothing is
    // strobed while reset is held.
    always_comb begin
        fifo_rden   = 1'b0;
        fifo_araddr = 5'd0;
        if (!rstn) begin
            fifo_rden   = 1'b0;
            fifo_araddr = 5'd0;
        end else if (fsm_rden) begin
            fifo_rden   = 1'b1;
            fifo_araddr = fsm_addr;
        end else begin
            fifo_rden   = sw_rden && !(enable && is_txst_addr(sw_araddr));
            fifo_araddr = sw_araddr;
        end
    end

    // State register and GAP timer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= (state_q == ST_GAP) ? gap_q + GAP_W'(1) : '0;
        end
    end

    // Capture each fwft word in the same cycle it is popped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w1_q <= '0;
            w2_q <= '0;
            w3_q <= '0;
            w4_q <= '0;
        end else begin
            if (state_q == ST_RD1) w1_q <= st_w1;
            if (state_q == ST_RD2) w2_q <= st_w2;
            if (state_q == ST_RD3) w3_q <= st_w3;
            if (state_q == ST_RD4) w4_q <= st_w4;
        end
    end

    // Pending records and stall timer feeding the interrupt
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q  <= '0;
            stall_q <= '0;
        end else begin
            if (state_q == ST_RD4)  pend_q <= pend_q + PEND_W'(1);
            else if (handshake)     pend_q <= pend_q - PEND_W'(1);
            if (state_q == ST_OUT && !rec_ready) begin
                if (!stall_q[8]) stall_q <= stall_q + 9'd1;
            end else begin
                stall_q <= '0;
            end
        end
    end

    // Statistics: delivered records wrap, blocked software reads saturate
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rec_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (handshake) rec_cnt_q <= rec_cnt_q + CNT_W'(1);
            if (sw_hit && (drop_cnt_q != {CNT_W{1'b1}}))
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    tx_status_unpack u_unpack (
        .w1  (w1_q),
        .w2  (w2_q),
        .w3  (w3_q),
        .w4  (w4_q),
        .rec (rec)
    );

    assign rec_valid       = (state_q == ST_OUT);
    assign rec_cw          = rec.cw;
    assign rec_num_slot    = rec.num_slot;
    assign rec_linux_prio  = rec.linux_prio;
    assign rec_queue_idx   = rec.queue_idx;
    assign rec_bd_idx      = rec.bd_idx;
    assign rec_num_retrans = rec.num_retrans;
    assign rec_ssn         = rec.ssn;
    assign rec_pkt_cnt     = rec.pkt_cnt;
    assign rec_bitmap      = rec.bitmap;
    assign irq             = (pend_q >= PEND_W'(IRQ_THRESH)) || stall_q[8];
    assign rec_cnt         = rec_cnt_q;
    assign sw_drop_cnt     = drop_cnt_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/tx_status_drain.md
Name: tx_status_drain

Overview:
- Hardware reader for the tx status FIFO bank. It replaces driver register polling when enabled.
- Polls status word 1 and, if it is non-empty, pops the four status words in order (core addresses 0x16..0x19) through the same rden/araddr strobe interface.
- Unpacks the words into a typed record and presents it on a valid/ready stream to the tx-completion/BD-recycle logic.
- Sits between the tx_intf AXI slave read mux and the tx status FIFO bank.

Parameters:
- GAP_CYCLES, 2: idle cycles after a record pop before the next poll. Covers the one-cycle lag of the registered empty flags; minimum legal value 2.
- IRQ_THRESH, 4: irq asserts when undelivered records counted reaches this value.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  1 = block owns status reads; 0 = transparent pass-through
- sw_rden  in  1  software slv_reg_rden
- sw_araddr  in  5  software axi_araddr_core
- fifo_rden  out  1  slv_reg_rden to the FIFO bank
- fifo_araddr  out  5  axi_araddr_core to the FIFO bank
- st_w1, st_w2, st_w3, st_w4  in  32 each  FIFO outputs (fwft); w1 = 0xFFFFFFFF means empty
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_cw  out  4  st_w1[31:28]
- rec_num_slot  out  9  st_w1[27:19]
- rec_linux_prio  out  2  st_w1[18:17]
- rec_queue_idx  out  2  st_w1[16:15]
- rec_bd_idx  out  6  st_w1[10:5]
- rec_num_retrans  out  4  st_w1[3:0]
- rec_ssn  out  12  st_w2[17:6]
- rec_pkt_cnt  out  6  st_w2[5:0]
- rec_bitmap  out  64  {st_w4, st_w3}
- irq  out  1  level, pending records >= IRQ_THRESH
- rec_cnt  out  CNT_W  records delivered
- sw_drop_cnt  out  CNT_W  software status reads blocked while enabled

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Reset applies asynchronously and may occur mid-record; the partial record is discarded and no strobe is issued during reset.
- Strobe mux:
  - enable = 0: fifo_rden = sw_rden and fifo_araddr = sw_araddr, combinationally; the FSM is held in IDLE.
  - enable = 1: the FSM drives the strobes. sw_araddr and sw_rden still pass through for addresses outside 0x16..0x19. Software strobes to 0x16..0x19 are suppressed and increment sw_drop_cnt (saturating).
- FSM states: IDLE, POLL, RD1, RD2, RD3, RD4, OUT, GAP.
  - IDLE -> POLL when enable = 1.
  - POLL: sample st_w1. If it is 0xFFFFFFFF, stay in POLL. Otherwise go to RD1.
  - RD1..RD4: each state lasts one cycle. It drives fifo_rden = 1 with fifo_araddr = 0x16 / 0x17 / 0x18 / 0x19 and captures the corresponding st_wN into the record register in the same cycle (fwft data is valid before the pop).
  - RD4 -> OUT. rec_valid rises on the cycle after RD4, so POLL-detect to rec_valid latency is 5 cycles.
  - OUT: hold rec_valid and all rec_* stable until rec_ready = 1. On the handshake, rec_cnt increments (wraps at 2^CNT_W) and the FSM goes to GAP.
  - GAP: count GAP_CYCLES, then go to POLL.
  - enable dropping to 0 is honoured only in IDLE, POLL and GAP (go to IDLE). A record in RD1..OUT is completed and delivered first.
- Pending counter (pend): tracks records in flight to the consumer. Increment at RD4, decrement at the OUT handshake. The block holds only one record, so pend is 0..1 in this configuration; IRQ_THRESH > 1 therefore requires the external skid. irq = (pend >= IRQ_THRESH) OR (rec_valid held for longer than 255 cycles).
- Reserved bits st_w1[14:11], st_w1[4] and st_w2[31:18] are ignored; no consistency check is made.
- Empty marker: a genuine word-1 value of 0xFFFFFFFF cannot occur because st_w1[4] is always 0.

Decomposition:
- Shared package tx_intf_pkg:
  - address constants TXST_ADDR_W1..W4 = 5'h16..5'h19
  - TXST_EMPTY = 32'hFFFFFFFF
  - packed typedef tx_status_rec_t
  - bit-field position constants for word 1 and word 2
- One natural sub-module: tx_status_unpack, the combinational word-to-record field extraction, reusable by the driver-model testbench.

Test Plan:
- Empty poll: enable = 1 with st_w1 = 0xFFFFFFFF held for 20 cycles -> fifo_rden never asserts, rec_valid = 0, FSM stays in POLL.
- Single record: st_w1 = 0x5A3C_0A27, st_w2 = 0x0001_2345, st_w3 = 0xDEADBEEF, st_w4 = 0x01234567.
  - Expect fifo_rden pulses at addresses 16, 17, 18, 19 on consecutive cycles.
  - 5 cycles later rec_valid = 1 with rec_cw = 5, rec_num_slot = 0x147, rec_bd_idx = 0x11, rec_num_retrans = 7, rec_ssn = 0x48D, rec_pkt_cnt = 5, rec_bitmap = 0x01234567DEADBEEF.
  - With rec_ready = 1, rec_cnt = 1.
- Backpressure: rec_ready = 0 for 300 cycles -> rec_valid and fields stable, no further fifo_rden, irq = 1 after 255 cycles; rec_ready = 1 -> irq clears and the GAP of 2 cycles precedes the next POLL.
- Software collision: enable = 1 and sw_rden = 1 to address 0x17 -> fifo_rden stays 0 that cycle (when the FSM is idle), sw_drop_cnt = 1. The same access to address 0x05 passes through.
- Pass-through: enable = 0 -> fifo_rden and fifo_araddr mirror sw_rden and sw_araddr exactly for a 16-access random sequence.
- Reset mid-record: assert rstn = 0 during RD2 -> all outputs 0 immediately; after release, the next poll re-reads from RD1 and no partial record is emitted.
